zombie_lane_engine: RTL and testbench
=====================================

ZOMBIE_LANE_ENGINE -- requirements
Module: zombie_lane_engine

Interface
REQ-001 Parameter NUM_LANES, default 5, number of zombie lanes.
REQ-002 Parameter X_W, default 10, lane X-position width.
REQ-003 Parameter TICK_DIV, default 500000, clocks per move step at level 1.
REQ-004 Parameter START_X, default 639, spawn position. Parameter END_X, default 0, lawn end.
REQ-005 Parameter KILLS_PER_LEVEL, default 8, kills that clear a level.
REQ-006 One clock; reset is asynchronous and active-low: clk input 1 system clock; reset_n input 1 async active-low reset.
REQ-007 start  input  1  single-cycle pulse; starts the game, advances between levels, restarts after game end.
REQ-008 spawn_req  input  NUM_LANES  per-lane spawn request, one bit per lane.
REQ-009 hit  input  NUM_LANES  per-lane kill pulse from plant/projectile logic.
REQ-010 zombie_x  output  NUM_LANES*X_W  packed lane positions; lane i is at bits [i*X_W +: X_W].
REQ-011 zombie_active  output  NUM_LANES  lane holds a live zombie.
REQ-012 state  output  8  one-hot game state {DONE_W, DONE_L, L3, NL3, L2, NL2, L1, I}, with I at bit 0.
REQ-013 level  output  2  current level, 0 in I, 1 to 3 otherwise.
REQ-014 zombies_killed  output  16  total kills this game. move_tick  output  1  one-cycle pulse on each move step.

Function
REQ-015 The FSM SHALL hold states I, L1, NL2, L2, NL3, L3, DONE_L and DONE_W, registered and one-hot.
REQ-016 Transitions SHALL be: I+start->L1; L1 clear->NL2; NL2+start->L2; L2 clear->NL3; NL3+start->L3; L3 clear->DONE_W; any Lx loss->DONE_L; DONE_L or DONE_W +start->I.
REQ-017 The move divider SHALL run only in L1/L2/L3 and SHALL count 0 to (TICK_DIV>>(level-1))-1; move_tick SHALL assert in the terminal-count cycle, so speed doubles per level.
REQ-018 The divider SHALL reset to 0 on every state change.
REQ-019 On move_tick, each active lane SHALL decrement X by 1; inactive lanes SHALL hold their position.
REQ-020 Loss: an active lane whose decremented X equals END_X SHALL cause DONE_L on the following cycle.
REQ-021 Spawn: in an Lx state, spawn_req[i] with lane i inactive SHALL set active and X=START_X next cycle; the request is ignored if lane i is active or the state is not Lx.
REQ-022 Kill: hit[i] on an active lane SHALL clear active; hit on an inactive lane SHALL be ignored.
REQ-023 Same-cycle hits on multiple lanes SHALL add their popcount to zombies_killed and to the level kill count.
REQ-024 zombies_killed SHALL saturate at 16'hFFFF.
REQ-025 Same-cycle hit and move_tick on one lane: the hit wins; the lane clears and raises no loss.
REQ-026 Same-cycle hit and spawn_req on one lane: the hit clears the lane and the spawn is dropped.
REQ-027 Same-cycle loss and level clear: the loss wins and the FSM goes to DONE_L.
REQ-028 Level clear occurs when the level kill count reaches KILLS_PER_LEVEL.
REQ-029 On entry to NLx, DONE_L or DONE_W, all lanes SHALL clear and the level kill count SHALL reset.
REQ-030 zombies_killed SHALL hold through NLx/DONE states and SHALL clear on entry to I.
REQ-031 start SHALL be ignored in L1/L2/L3.

Reset
REQ-032 Assertion of reset_n low SHALL immediately force: state=I, level=0, zombies_killed=0, zombie_active=0, all zombie_x=START_X, divider=0, move_tick=0.
REQ-033 Reset mid-game SHALL discard all lane state; no loss or win is reported.
REQ-034 reset_n deassertion is synchronised externally; the first start sampled after deassertion SHALL enter L1.

Structure
REQ-035 A shared package zombie_pkg SHALL hold the state one-hot localparams, lawn constants (START_X, END_X) and level count.
REQ-036 One sub-module, zombie_lane, SHALL implement a single lane (active, X, spawn/hit/tick priority, loss flag).
REQ-037 zombie_lane SHALL be instantiated NUM_LANES times by generate.
REQ-038 The top level SHALL hold the FSM, the divider and the kill counters.

Verification (TICK_DIV=4, START_X=5, KILLS_PER_LEVEL=2)
REQ-039 Reset, start, spawn lane 0 -> zombie_active[0]=1, x0=5; x0 decrements every 4 clocks; DONE_L one cycle after x0=0.
REQ-040 In L1, spawn lanes 1 and 3, then hit both in one cycle -> zombies_killed=2, next state NL2, all lanes inactive.
REQ-041 NL2, start -> L2, level=2; move_tick period becomes 2 clocks.
REQ-042 Lane at x=1, hit coincident with move_tick -> lane cleared, no DONE_L, kill counted.
REQ-043 Clear L3 -> DONE_W; start -> I with zombies_killed=0.
REQ-044 reset_n low mid-L2 with 3 active lanes -> same cycle state=I, all outputs at reset values.

Source files
------------

// File: rtl/zombie_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the zombie lane game: one-hot game states, default lawn
// geometry, level count and the move-divider terminal-count helper.
package zombie_pkg;

  localparam logic [7:0] ST_I      = 8'h01;
  localparam logic [7:0] ST_L1     = 8'h02;
  localparam logic [7:0] ST_NL2    = 8'h04;
  localparam logic [7:0] ST_L2     = 8'h08;
  localparam logic [7:0] ST_NL3    = 8'h10;
  localparam logic [7:0] ST_L3     = 8'h20;
  localparam logic [7:0] ST_DONE_L = 8'h40;
  localparam logic [7:0] ST_DONE_W = 8'h80;

  typedef enum logic [7:0] {
    S_I      = ST_I,
    S_L1     = ST_L1,
    S_NL2    = ST_NL2,
    S_L2     = ST_L2,
    S_NL3    = ST_NL3,
    S_L3     = ST_L3,
    S_DONE_L = ST_DONE_L,
    S_DONE_W = ST_DONE_W
  } state_e;

  localparam int LAWN_START_X = 639;
  localparam int LAWN_END_X   = 0;
  localparam int NUM_LEVELS   = 3;

  // Last divider count for a level; the period halves each level and never drops below one clock.
  function automatic int div_term(input int tick_div, input int lvl);
    int period;
    period = tick_div >> (lvl - 1);
    return (period > 0) ? period - 1 : 0;
  endfunction

endpackage

// File: rtl/zombie_lane.sv
`timescale 1ns/1ps
// One zombie lane: holds liveness and X position, applies flush > hit > spawn > move
// priority, and raises a sticky loss flag when the zombie reaches the end of the lawn.
module zombie_lane
  import zombie_pkg::*;
#(
  parameter int X_W     = 10,
  parameter int START_X = LAWN_START_X,
  parameter int END_X   = LAWN_END_X
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           flush_i,
  input  logic           run_i,
  input  logic           spawn_i,
  input  logic           hit_i,
  input  logic           tick_i,
  output logic           active_o,
  output logic [X_W-1:0] x_o,
  output logic           loss_o
);

  localparam logic [X_W-1:0] X_START = X_W'(START_X);
  localparam logic [X_W-1:0] X_END   = X_W'(END_X);

  logic           active_q, active_d;
  logic [X_W-1:0] x_q, x_d;
  logic           loss_q, loss_d;

  always_comb begin
    // NOTE: every next-state signal takes its hold value first, so no branch can infer a latch.
    active_d = active_q;
    x_d      = x_q;
    loss_d   = loss_q;
    if (flush_i) begin
      active_d = 1'b0;
      x_d      = X_START;
      loss_d   = 1'b0;
    end else if (hit_i) begin
      // A hit beats a same-cycle move (no loss) and drops a same-cycle spawn.
      active_d = 1'b0;
    end else if (!active_q) begin
      if (spawn_i && run_i) begin
        active_d = 1'b1;
        x_d      = X_START;
      end
    end else if (tick_i && (x_q != X_END)) begin
      x_d = x_q - 1'b1;
      if (x_d == X_END) loss_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: async reset puts the lane at its spawn point; non-blocking keeps all flops in step.
    if (!reset_n) begin
      active_q <= 1'b0;
      x_q      <= X_START;
      loss_q   <= 1'b0;
    end else begin
      active_q <= active_d;
      x_q      <= x_d;
      loss_q   <= loss_d;
    end
  end

  assign active_o = active_q;
  assign x_o      = x_q;
  assign loss_o   = loss_q;

endmodule

// File: rtl/zombie_lane_engine.sv
`timescale 1ns/1ps
// Zombie lane game engine: level FSM, per-level move divider, kill counters and
// NUM_LANES independent lanes.
module zombie_lane_engine
  import zombie_pkg::*;
#(
  parameter int NUM_LANES       = 5,
  parameter int X_W             = 10,
  parameter int TICK_DIV        = 500000,
  parameter int START_X         = LAWN_START_X,
  parameter int END_X           = LAWN_END_X,
  parameter int KILLS_PER_LEVEL = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [NUM_LANES-1:0]     spawn_req,
  input  logic [NUM_LANES-1:0]     hit,
  output logic [NUM_LANES*X_W-1:0] zombie_x,
  output logic [NUM_LANES-1:0]     zombie_active,
  output logic [7:0]               state,
  output logic [1:0]               level,
  output logic [15:0]              zombies_killed,
  output logic                     move_tick
);

  localparam int DIV_W = $clog2(TICK_DIV + 1);
  localparam int LK_W  = $clog2(KILLS_PER_LEVEL + NUM_LANES + 1);
  localparam int CNT_W = $clog2(NUM_LANES + 1);

  localparam logic [DIV_W-1:0] TERM_L1 = DIV_W'(div_term(TICK_DIV, 1));
  localparam logic [DIV_W-1:0] TERM_L2 = DIV_W'(div_term(TICK_DIV, 2));
  localparam logic [DIV_W-1:0] TERM_L3 = DIV_W'(div_term(TICK_DIV, NUM_LEVELS));

  state_e            state_q;
  state_e            clear_next;
  logic [1:0]        level_q;
  logic [DIV_W-1:0]  div_q;
  logic [DIV_W-1:0]  term_sel;
  logic [15:0]       kills_q;
  logic [LK_W-1:0]   lvl_kills_q;
  logic [LK_W-1:0]   lvl_kills_sum;
  logic [16:0]       kills_sum;
  logic [CNT_W-1:0]  kill_cnt;
  logic [NUM_LANES-1:0] kill_mask;
  logic [NUM_LANES-1:0] lane_loss;
  logic              in_lx;
  logic              loss_any;
  logic              level_clear;
  logic              lane_flush;

  assign in_lx = state_q inside {S_L1, S_L2, S_L3};

  always_comb begin
    case (level_q)
      2'd1:    term_sel = TERM_L1;
      2'd2:    term_sel = TERM_L2;
      default: term_sel = TERM_L3;
    endcase
  end

  assign move_tick = in_lx && (div_q == term_sel);

  // Only hits that land on a live zombie count as kills.
  assign kill_mask = hit & zombie_active;

  always_comb begin
    kill_cnt = '0;
    for (int i = 0; i < NUM_LANES; i++) kill_cnt = kill_cnt + CNT_W'(kill_mask[i]);
  end

  assign kills_sum     = {1'b0, kills_q} + 17'(kill_cnt);
  assign lvl_kills_sum = lvl_kills_q + LK_W'(kill_cnt);
  assign loss_any      = |lane_loss;
  assign level_clear   = lvl_kills_sum >= LK_W'(KILLS_PER_LEVEL);
  assign lane_flush    = in_lx && (loss_any || level_clear);

  always_comb begin
    case (state_q)
      S_L1:    clear_next = S_NL2;
      S_L2:    clear_next = S_NL3;
      default: clear_next = S_DONE_W;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_I;
      level_q     <= '0;
      div_q       <= '0;
      kills_q     <= '0;
      lvl_kills_q <= '0;
    end else begin
      case (state_q)
        S_I: if (start) begin
          state_q     <= S_L1;
          level_q     <= 2'd1;
          div_q       <= '0;
          lvl_kills_q <= '0;
        end
        S_L1, S_L2, S_L3: begin
          kills_q <= kills_sum[16] ? 16'hFFFF : kills_sum[15:0];
          // Loss outranks a same-cycle level clear.
          if (loss_any) begin
            state_q     <= S_DONE_L;
            div_q       <= '0;
            lvl_kills_q <= '0;
          end else if (level_clear) begin
            state_q     <= clear_next;
            div_q       <= '0;
            lvl_kills_q <= '0;
          end else begin
            lvl_kills_q <= lvl_kills_sum;
            div_q       <= move_tick ? '0 : div_q + 1'b1;
          end
        end
        S_NL2: if (start) begin
          state_q <= S_L2;
          level_q <= 2'd2;
          div_q   <= '0;
        end
        S_NL3: if (start) begin
          state_q <= S_L3;
          level_q <= 2'(NUM_LEVELS);
          div_q   <= '0;
        end
        S_DONE_L, S_DONE_W: if (start) begin
          state_q <= S_I;
          level_q <= '0;
          kills_q <= '0;
        end
        default: begin
          state_q     <= S_I;
          level_q     <= '0;
          div_q       <= '0;
          kills_q     <= '0;
          lvl_kills_q <= '0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    zombie_lane #(
      .X_W     (X_W),
      .START_X (START_X),
      .END_X   (END_X)
    ) u_lane (
      .clk      (clk),
      .reset_n  (reset_n),
      .flush_i  (lane_flush),
      .run_i    (in_lx),
      .spawn_i  (spawn_req[i]),
      .hit_i    (hit[i]),
      .tick_i   (move_tick),
      .active_o (zombie_active[i]),
      .x_o      (zombie_x[i*X_W +: X_W]),
      .loss_o   (lane_loss[i])
    );
  end

  assign state          = state_q;
  assign level          = level_q;
  assign zombies_killed = kills_q;

endmodule

// File: tb/tb_zombie_lane_engine.sv
`timescale 1ns/1ps
// Scoreboard bench for zombie_lane_engine with TICK_DIV=4, START_X=5, END_X=0, KILLS_PER_LEVEL=2.
module tb_zombie_lane_engine;

  localparam int NL  = 5;
  localparam int X_W = 10;

  localparam logic [7:0] E_I      = 8'h01;
  localparam logic [7:0] E_L1     = 8'h02;
  localparam logic [7:0] E_NL2    = 8'h04;
  localparam logic [7:0] E_L2     = 8'h08;
  localparam logic [7:0] E_NL3    = 8'h10;
  localparam logic [7:0] E_L3     = 8'h20;
  localparam logic [7:0] E_DONE_L = 8'h40;
  localparam logic [7:0] E_DONE_W = 8'h80;

  logic              clk;
  logic              reset_n;
  logic              start;
  logic [NL-1:0]     spawn_req;
  logic [NL-1:0]     hit;
  logic [NL*X_W-1:0] zombie_x;
  logic [NL-1:0]     zombie_active;
  logic [7:0]        state;
  logic [1:0]        level;
  logic [15:0]       zombies_killed;
  logic              move_tick;

  typedef struct {
    string       name;
    logic [7:0]  st;
    int          lvl;   // -1: not checked
    logic [15:0] kills;
    logic [NL-1:0] act;
    int          lane;  // -1: no X check
    logic [X_W-1:0] x;
    int          tick;  // -1: not checked
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  zombie_lane_engine #(
    .NUM_LANES       (NL),
    .X_W             (X_W),
    .TICK_DIV        (4),
    .START_X         (5),
    .END_X           (0),
    .KILLS_PER_LEVEL (2)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .spawn_req      (spawn_req),
    .hit            (hit),
    .zombie_x       (zombie_x),
    .zombie_active  (zombie_active),
    .state          (state),
    .level          (level),
    .zombies_killed (zombies_killed),
    .move_tick      (move_tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got time %0t, required finish before 200000", $time);
    $fatal(1);
  end

  task automatic push(input string name, input logic [7:0] st, input int lvl, input logic [15:0] kills,
                      input logic [NL-1:0] act, input int lane, input logic [X_W-1:0] x, input int tick);
    exp_t e;
    e.name = name; e.st = st; e.lvl = lvl; e.kills = kills;
    e.act = act; e.lane = lane; e.x = x; e.tick = tick;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every queued expectation against the settled outputs at the falling edge.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      bit ok;
      logic [X_W-1:0] xa;
      e  = sb.pop_front();
      xa = '0;
      ok = (state == e.st) && (zombies_killed == e.kills) && (zombie_active == e.act);
      if (e.lvl >= 0) ok = ok && (level == 2'(e.lvl));
      if (e.lane >= 0) begin
        xa = zombie_x[e.lane*X_W +: X_W];
        ok = ok && (xa == e.x);
      end
      if (e.tick >= 0) ok = ok && (move_tick == e.tick[0]);
      vectors++;
      if (!ok) begin
        miscompares++;
        $display("FAIL %s: got state=%h level=%0d kills=%0d active=%b x=%0d tick=%b; want state=%h level=%0d kills=%0d active=%b x[lane %0d]=%0d tick=%0d",
                 e.name, state, level, zombies_killed, zombie_active, xa, move_tick,
                 e.st, e.lvl, e.kills, e.act, e.lane, e.x, e.tick);
      end
    end
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; spawn_req = '0; hit = '0;
    repeat (2) @(posedge clk);
    #1;
    push("reset", E_I, 0, 0, 5'b00000, 0, 5, 0);
    step();
    reset_n = 1'b1;
    step();

    // Single lane walks down the lawn and loses.
    start = 1'b1; step(); start = 1'b0;
    push("l1_entry", E_L1, 1, 0, 5'b00000, -1, 0, 0);
    spawn_req = 5'b00001; step(); spawn_req = '0;
    push("spawn0", E_L1, 1, 0, 5'b00001, 0, 5, 0);
    repeat (2) step();
    push("first_tick", E_L1, 1, 0, 5'b00001, 0, 5, 1);
    step();
    push("x0_4", E_L1, 1, 0, 5'b00001, 0, 4, 0);
    repeat (4) step();
    push("x0_3", E_L1, 1, 0, 5'b00001, 0, 3, 0);
    repeat (8) step();
    push("x0_1", E_L1, 1, 0, 5'b00001, 0, 1, 0);
    repeat (4) step();
    push("x0_end", E_L1, 1, 0, 5'b00001, 0, 0, 0);
    step();
    push("loss", E_DONE_L, 1, 0, 5'b00000, 0, 5, 0);
    start = 1'b1; step(); start = 1'b0;
    push("restart", E_I, 0, 0, 5'b00000, -1, 0, 0);

    // Double kill clears level 1; the hit on empty lane 0 is ignored.
    start = 1'b1; step(); start = 1'b0;
    spawn_req = 5'b01010; step(); spawn_req = '0;
    push("spawn13", E_L1, 1, 0, 5'b01010, 1, 5, -1);
    hit = 5'b01011; step(); hit = '0;
    push("double_kill", E_NL2, -1, 2, 5'b00000, 3, 5, 0);

    // Level 2: faster ticks, hit coincident with a move at x=1.
    start = 1'b1; step(); start = 1'b0;
    push("l2_entry", E_L2, 2, 2, 5'b00000, -1, 0, 0);
    spawn_req = 5'b00100; step(); spawn_req = '0;
    push("l2_tick", E_L2, 2, 2, 5'b00100, 2, 5, 1);
    step();
    push("x2_4", E_L2, 2, 2, 5'b00100, 2, 4, 0);
    repeat (6) step();
    push("x2_1", E_L2, 2, 2, 5'b00100, 2, 1, 0);
    step();
    push("pre_hit", E_L2, 2, 2, 5'b00100, 2, 1, 1);
    hit = 5'b00100; step(); hit = '0;
    push("hit_tick", E_L2, 2, 3, 5'b00000, -1, 0, 0);
    step();
    push("no_loss", E_L2, 2, 3, 5'b00000, -1, 0, -1);
    spawn_req = 5'b10000; hit = 5'b10000; step(); spawn_req = '0; hit = '0;
    push("hit_spawn", E_L2, 2, 3, 5'b00000, -1, 0, -1);
    spawn_req = 5'b10000; step(); spawn_req = '0;
    push("spawn4", E_L2, 2, 3, 5'b10000, -1, 0, -1);
    hit = 5'b10000; step(); hit = '0;
    push("l2_clear", E_NL3, -1, 4, 5'b00000, -1, 0, 0);

    // Level 3: tick every clock, start ignored, win then back to idle.
    start = 1'b1; step(); start = 1'b0;
    push("l3_entry", E_L3, 3, 4, 5'b00000, -1, 0, 1);
    start = 1'b1; spawn_req = 5'b00011; step(); start = 1'b0; spawn_req = '0;
    push("l3_start_ignored", E_L3, 3, 4, 5'b00011, 0, 5, 1);
    hit = 5'b00011; step(); hit = '0;
    push("win", E_DONE_W, 3, 6, 5'b00000, 0, 5, 0);
    start = 1'b1; step(); start = 1'b0;
    push("win_restart", E_I, 0, 0, 5'b00000, 0, 5, 0);

    // Reset in the middle of level 2 with three live lanes.
    start = 1'b1; step(); start = 1'b0;
    spawn_req = 5'b00011; step(); spawn_req = '0;
    hit = 5'b00011; step(); hit = '0;
    start = 1'b1; step(); start = 1'b0;
    spawn_req = 5'b00111; step(); spawn_req = '0;
    push("l2_three", E_L2, 2, 2, 5'b00111, 1, 5, -1);
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    push("async_reset", E_I, 0, 0, 5'b00000, 2, 5, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step();
    start = 1'b1; step(); start = 1'b0;
    push("post_reset_start", E_L1, 1, 0, 5'b00000, -1, 0, 0);
    step();
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d unchecked expectations, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
